// File: rtl/move_input.sv
// Button front-end for Score 4: synchronise, debounce and edge-detect the raw
// left/right/put buttons into single-cycle move requests, with left/right autorepeat.
module move_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_put,
    input  logic enable,
    output logic left,
    output logic right,
    output logic put
);
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);
    localparam int L = 0;
    localparam int R = 1;
    localparam int P = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [2:0]     btn_s;
    logic [2:0]     s1_r;
    logic [2:0]     s2_r;
    logic [2:0]     st_r;
    logic [DCW-1:0] cnt_r [3];
    logic [2:0]     flip_s;
    logic [2:0]     rise_s;
    logic           st_next_l_s;
    logic           st_next_r_s;
    logic           dir_fall_s;
    logic           opp_on_s;
    logic [RCW-1:0] rlast_s;

    state_t         state_r;
    logic           dir_r;      // 0: left, 1: right
    logic [RCW-1:0] rcnt_r;

    assign btn_s = {btn_put, btn_right, btn_left};

    // Two-stage synchroniser and per-button debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 3'b000;
            s2_r <= 3'b000;
            st_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= {DCW{1'b0}};
            end
        end else begin
            s1_r <= btn_s;
            s2_r <= s1_r;
            st_r <= st_r ^ flip_s;
            for (int i = 0; i < 3; i++) begin
                if ((s2_r[i] == st_r[i]) || flip_s[i]) begin
                    cnt_r[i] <= {DCW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + DCW'(1);
                end
            end
        end
    end

    // Debounced level changes due at this edge, and the FSM's view of them.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            flip_s[i] = (s2_r[i] != st_r[i]) && (cnt_r[i] == DB_LAST);
        end
        rise_s      = flip_s & ~st_r;
        st_next_l_s = st_r[L] ^ flip_s[L];
        st_next_r_s = st_r[R] ^ flip_s[R];
        dir_fall_s  = dir_r ? (flip_s[R] & st_r[R]) : (flip_s[L] & st_r[L]);
        opp_on_s    = dir_r ? st_next_l_s : st_next_r_s;
        rlast_s     = (state_r == DELAY) ? DELAY_LAST : PERIOD_LAST;
    end

    // Left/right repeat FSM with put priority and enable masking on the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            rcnt_r  <= {RCW{1'b0}};
            left    <= 1'b0;
            right   <= 1'b0;
            put     <= 1'b0;
        end else begin
            put   <= enable & rise_s[P];
            left  <= 1'b0;
            right <= 1'b0;
            case (state_r)
                IDLE: begin
                    rcnt_r <= {RCW{1'b0}};
                    if (rise_s[L] && !st_next_r_s) begin
                        dir_r <= 1'b0;
                        left  <= enable & ~rise_s[P];
                        if (REPEAT_EN != 32'sd0) begin
                            state_r <= DELAY;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (rise_s[R] && !st_next_l_s) begin
                        dir_r <= 1'b1;
                        right <= enable & ~rise_s[P];
                        if (REPEAT_EN != 32'sd0) begin
                            state_r <= DELAY;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DELAY, REPEAT: begin
                    if (dir_fall_s || opp_on_s || (REPEAT_EN == 32'sd0)) begin
                        state_r <= IDLE;
                        rcnt_r  <= {RCW{1'b0}};
                    end else if (rcnt_r == rlast_s) begin
                        state_r <= REPEAT;
                        rcnt_r  <= {RCW{1'b0}};
                        if (dir_r) begin
                            right <= enable & ~rise_s[P];
                        end else begin
                            left  <= enable & ~rise_s[P];
                        end
                    end else begin
                        rcnt_r <= rcnt_r + RCW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rcnt_r  <= {RCW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_input.sv
// Bench for move_input: directed scenario table with per-edge expected pulse masks,
// then randomised bouncy buttons checked against a behavioural model.
module tb_move_input;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_put = 1'b0;
    logic enable = 1'b1;
    logic left, right, put;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    move_input #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(1),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_put(btn_put),
        .enable(enable),
        .left(left),
        .right(right),
        .put(put)
    );

    // Raw buttons are high on edges [on, off); rst on [rst_on, rst_off); enable from en_edge.
    typedef struct {
        string       name;
        int          l_on, l_off, r_on, r_off, p_on, p_off;
        int          en_edge, rst_on, rst_off;
        bit          bounce_l;
        logic [63:0] exp_l, exp_r, exp_p;
    } vec_t;

    function automatic vec_t mk(input string n, input int lon, input int loff,
                                input int ron, input int roff, input int pon, input int poff,
                                input int en_e, input int r_on, input int r_off, input bit bl,
                                input logic [63:0] el, input logic [63:0] er, input logic [63:0] ep);
        vec_t v;
        v.name = n; v.l_on = lon; v.l_off = loff; v.r_on = ron; v.r_off = roff;
        v.p_on = pon; v.p_off = poff; v.en_edge = en_e; v.rst_on = r_on; v.rst_off = r_off;
        v.bounce_l = bl; v.exp_l = el; v.exp_r = er; v.exp_p = ep;
        return v;
    endfunction

    task automatic check(input string name, input int m, input logic [2:0] got, input logic [2:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s edge %0d: {left,right,put} got %b expected %b", name, m, got, want);
        end
    endtask

    // Behavioural model: 2-sample delay, "DB consecutive disagreeing samples" debounce,
    // and repeat timing from the edge number of the initial pulse.
    bit mq[3][$];
    bit mst[3];
    int mrun[3];
    bit mact;
    int mdir;
    int mpress;
    int medge = 0;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            mq[b].delete();
            mq[b].push_back(1'b0);
            mq[b].push_back(1'b0);
            mst[b] = 1'b0;
            mrun[b] = 0;
        end
        mact = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit [2:0] raw, input bit en, output logic [2:0] exp);
        bit v;
        bit rise[3];
        bit fall[3];
        bit lp, rp;
        int d;
        exp = 3'b000;
        if (r) begin
            model_reset();
        end else begin
            for (int b = 0; b < 3; b++) begin
                v = mq[b].pop_front();
                mq[b].push_back(raw[b]);
                rise[b] = 1'b0;
                fall[b] = 1'b0;
                if (v != mst[b]) begin
                    mrun[b]++;
                    if (mrun[b] == DB) begin
                        mst[b] = v;
                        mrun[b] = 0;
                        rise[b] = v;
                        fall[b] = !v;
                    end
                end else begin
                    mrun[b] = 0;
                end
            end
            lp = 1'b0;
            rp = 1'b0;
            if (!mact) begin
                if (rise[0] && !mst[1]) begin
                    mact = 1'b1; mdir = 0; mpress = medge; lp = 1'b1;
                end else if (rise[1] && !mst[0]) begin
                    mact = 1'b1; mdir = 1; mpress = medge; rp = 1'b1;
                end
            end else if (fall[mdir] || mst[1 - mdir]) begin
                mact = 1'b0;
            end else begin
                d = medge - mpress;
                if (d == RD || (d > RD && (d - RD) % RP == 0)) begin
                    if (mdir == 1) rp = 1'b1;
                    else lp = 1'b1;
                end
            end
            exp = {en & lp & !rise[2], en & rp & !rise[2], en & rise[2]};
        end
        medge++;
    endtask

    initial begin
        vec_t vecs[NV];
        bit [2:0] target;
        bit [2:0] raw;
        logic [2:0] exp;

        vecs[0] = mk("clean_put",    0, 0,  0, 0,  0, 40, 0, 0, 0, 1'b0,
                     64'h0, 64'h0, 64'h20);
        vecs[1] = mk("bounce_left",  24, 33, 0, 0, 0, 0, 0, 0, 0, 1'b1,
                     64'h0000_0000_2000_0000, 64'h0, 64'h0);
        vecs[2] = mk("autorepeat",   0, 0,  0, 40, 0, 0,  0, 0, 0, 1'b0,
                     64'h0, 64'h0000_0108_4210_8020, 64'h0);
        vecs[3] = mk("conflict",     0, 64, 8, 64, 0, 0,  0, 0, 0, 1'b0,
                     64'h20, 64'h0, 64'h0);
        vecs[4] = mk("put_priority", 0, 18, 0, 0,  0, 18, 0, 0, 0, 1'b0,
                     64'h0000_0000_0010_8000, 64'h0, 64'h20);
        vecs[5] = mk("enable_mask",  0, 19, 0, 0,  0, 0,  12, 0, 0, 1'b0,
                     64'h0000_0000_0010_8000, 64'h0, 64'h0);
        vecs[6] = mk("reset_mid",    0, 0,  0, 30, 0, 0,  0, 12, 14, 1'b0,
                     64'h0, 64'h0000_0004_2008_0020, 64'h0);

        for (int s = 0; s < NV; s++) begin
            rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_put = 1'b0; enable = 1'b1;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk);
                @(negedge clk);
                check({vecs[s].name, "_rst"}, k, {left, right, put}, 3'b000);
            end
            for (int m = 0; m < 64; m++) begin
                rst       = (m >= vecs[s].rst_on) && (m < vecs[s].rst_off);
                enable    = (m >= vecs[s].en_edge);
                btn_left  = (vecs[s].bounce_l && m < 20 && (m % 4) != 3) ||
                            (m >= vecs[s].l_on && m < vecs[s].l_off);
                btn_right = (m >= vecs[s].r_on) && (m < vecs[s].r_off);
                btn_put   = (m >= vecs[s].p_on) && (m < vecs[s].p_off);
                @(posedge clk);
                @(negedge clk);
                check(vecs[s].name, m, {left, right, put},
                      {vecs[s].exp_l[m], vecs[s].exp_r[m], vecs[s].exp_p[m]});
            end
        end

        target = 3'b000;
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 39) == 0) target[b] = !target[b];
                raw[b] = target[b] ^ ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 79) == 0) enable = !enable;
            rst       = (i < 2) || ($urandom_range(0, 499) == 0);
            btn_left  = raw[0];
            btn_right = raw[1];
            btn_put   = raw[2];
            @(posedge clk);
            model_step(rst, raw, enable, exp);
            @(negedge clk);
            check("random", i, {left, right, put}, exp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
